// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I opcode constants, NOP word and instruction format classification
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_R:                      return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      default:                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field packer; unencodable field sets collapse to NOP
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [4:0]  Rd,
  input  logic [31:0] imme,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e        fmt;
  logic        is_shift;
  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic [31:0] raw;

  always_comb begin
    fmt      = fmt_of(opcode);
    is_shift = (opcode == OP_IMM) && ((func3 == 3'b001) || (func3 == 3'b101));
    // immediate must be a sign extension of the bits the format can hold
    i_ok     = (&imme[31:11]) || !(|imme[31:11]);
    b_ok     = ((&imme[31:12]) || !(|imme[31:12])) && !imme[0];
    j_ok     = ((&imme[31:20]) || !(|imme[31:20])) && !imme[0];
    raw      = '0;
    legal    = 1'b0;
    case (fmt)
      FMT_R: begin
        raw   = {1'b0, func7, 5'b00000, Rs2, Rs1, func3, Rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          raw   = {1'b0, func7, 5'b00000, imme[4:0], Rs1, func3, Rd, opcode};
          legal = (imme[31:5] == '0);
        end else begin
          raw   = {imme[11:0], Rs1, func3, Rd, opcode};
          legal = i_ok;
        end
      end
      FMT_S: begin
        raw   = {imme[11:5], Rs2, Rs1, func3, imme[4:0], opcode};
        legal = i_ok;
      end
      FMT_B: begin
        raw   = {imme[12], imme[10:5], Rs2, Rs1, func3, imme[4:1], imme[11], opcode};
        legal = b_ok;
      end
      FMT_U: begin
        raw   = {imme[31:12], Rd, opcode};
        legal = (imme[11:0] == '0);
      end
      FMT_J: begin
        raw   = {imme[20], imme[10:1], imme[11], imme[19:12], Rd, opcode};
        legal = j_ok;
      end
      default: begin
        raw   = '0;
        legal = 1'b0;
      end
    endcase
    word = legal ? raw : NOP;
  end

endmodule

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - burst-bounded RV32I encoder streaming packed words to instruction memory
module instr_encode
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              func7,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [4:0]        Rd,
  input  logic [31:0]       imme,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              illegal,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  acc_cnt;
  logic [LEN_W-1:0]  emit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       pk_word;
  logic              pk_legal;
  logic              in_fire;
  logic              out_fire;
  logic              last_out;

  instr_pack u_pack (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .Rs1    (Rs1),
    .Rs2    (Rs2),
    .Rd     (Rd),
    .imme   (imme),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign addr_out = addr_q;
  // one output register: accept only when it is empty or draining this cycle
  assign in_ready = busy && (acc_cnt < len_q) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_out = out_fire && (emit_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      acc_cnt   <= '0;
      emit_cnt  <= '0;
      addr_q    <= '0;
      out_valid <= 1'b0;
      instr_out <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= (len != '0) ? S_RUN : S_DONE;
            len_q    <= len;
            addr_q   <= base_addr;
            acc_cnt  <= '0;
            emit_cnt <= '0;
          end
        end
        S_RUN: begin
          if (last_out) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (in_fire) begin
        instr_out <= pk_word;
        illegal   <= !pk_legal;
        out_valid <= 1'b1;
        acc_cnt   <= acc_cnt + LEN_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (out_fire) begin
        addr_q   <= addr_q + ADDR_W'(1);
        emit_cnt <= emit_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
// tb/tb_instr_encode.sv - randomized self-checking bench for instr_encode against an arithmetic encoding model
module tb_instr_encode;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic              func7;
  logic [4:0]        Rs1;
  logic [4:0]        Rs2;
  logic [4:0]        Rd;
  logic [31:0]       imme;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] addr_out;
  logic              illegal;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encode #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .func3(func3),
    .func7(func7), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .imme(imme),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .addr_out(addr_out), .illegal(illegal), .busy(busy), .done(done)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    bit          has_exp;
    logic [31:0] exp_word;
    bit          exp_ill;
  } fields_t;

  typedef struct {
    logic [31:0] word;
    bit          ill;
  } exp_t;

  fields_t burst[$];

  function automatic fields_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] imm);
    fields_t f;
    f.op = op; f.f3 = f3; f.f7 = f7; f.rs1 = rs1; f.rs2 = rs2; f.rd = rd; f.imm = imm;
    f.has_exp = 1'b0; f.exp_word = '0; f.exp_ill = 1'b0;
    return f;
  endfunction

  function automatic fields_t mkx(input fields_t base, input logic [31:0] w, input bit ill);
    fields_t f = base;
    f.has_exp = 1'b1; f.exp_word = w; f.exp_ill = ill;
    return f;
  endfunction

  // Encoding rules written as value ranges and bit arithmetic on the numeric immediate
  function automatic exp_t model(input fields_t f);
    exp_t        e;
    int          s = $signed(f.imm);
    int unsigned u = f.imm;
    int unsigned w = 0;
    bit          ok = 1'b0;
    int unsigned base = 32'(f.op) | (32'(f.f3) << 12) | (32'(f.rs1) << 15);
    case (f.op)
      7'h33: begin
        ok = 1'b1;
        w  = base | (32'(f.rd) << 7) | (32'(f.rs2) << 20) | (32'(f.f7) << 30);
      end
      7'h13, 7'h03, 7'h67: begin
        if (f.op == 7'h13 && (f.f3 == 3'd1 || f.f3 == 3'd5)) begin
          ok = (u < 32);
          w  = base | (32'(f.rd) << 7) | ((u & 31) << 20) | (32'(f.f7) << 30);
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = base | (32'(f.rd) << 7) | ((u & 32'hFFF) << 20);
        end
      end
      7'h23: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = base | ((u & 31) << 7) | (32'(f.rs2) << 20) | (((u >> 5) & 32'h7F) << 25);
      end
      7'h63: begin
        ok = (s >= -4096) && (s <= 4095) && ((u & 1) == 0);
        w  = base | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hF) << 8) | (32'(f.rs2) << 20)
           | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 1) << 31);
      end
      7'h37, 7'h17: begin
        ok = ((u & 32'hFFF) == 0);
        w  = 32'(f.op) | (32'(f.rd) << 7) | (u & 32'hFFFFF000);
      end
      7'h6F: begin
        ok = (s >= -(1 << 20)) && (s < (1 << 20)) && ((u & 1) == 0);
        w  = 32'(f.op) | (32'(f.rd) << 7) | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 1) << 20)
           | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 1) << 31);
      end
      default: ok = 1'b0;
    endcase
    e.word = ok ? w : 32'h00000013;
    e.ill  = !ok;
    return e;
  endfunction

  function automatic exp_t expected(input fields_t f);
    exp_t e;
    if (f.has_exp) begin
      e.word = f.exp_word;
      e.ill  = f.exp_ill;
    end else begin
      e = model(f);
    end
    return e;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    logic [6:0] op;
    logic [31:0] imm;
    case ($urandom_range(0, 9))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h67;
      4: op = 7'h23;
      5: op = 7'h63;
      6: op = 7'h37;
      7: op = 7'h17;
      8: op = 7'h6F;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 80)) - 32'd40;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFFF000;
      default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
    f = mk(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    return f;
  endfunction

  task automatic apply_fields(input fields_t f);
    opcode = f.op; func3 = f.f3; func7 = f.f7;
    Rs1 = f.rs1; Rs2 = f.rs2; Rd = f.rd; imme = f.imm;
  endtask

  task automatic run_burst(input int base, input int ready_pct, input int valid_pct, input string tag);
    int   n = burst.size();
    int   idx = 0;
    int   got = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(base); len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    while (got < n && cyc < 40 * n + 100) begin
      if (idx < n && $urandom_range(1, 100) <= valid_pct) begin
        in_valid = 1'b1;
        apply_fields(burst[idx]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s spurious: got word %h with no accepted field set", tag, instr_out);
        end else begin
          e = q.pop_front();
          if (instr_out !== e.word || illegal !== e.ill || addr_out !== ADDR_W'(base + got)) begin
            n_fail++;
            $display("FAIL %s word%0d: got %h ill=%b addr=%0d, want %h ill=%b addr=%0d",
                     tag, got, instr_out, illegal, addr_out, e.word, e.ill, ADDR_W'(base + got));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(expected(burst[idx]));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d words, want %0d", tag, got, n);
    end
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: got done=%b busy=%b out_valid=%b, want 1 0 0", tag, done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
    apply_fields(mk(7'h0, 3'h0, 1'b0, 5'h0, 5'h0, 5'h0, 32'h0));
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({in_ready, out_valid, illegal, busy, done} !== 5'b0 || instr_out !== 32'h0 || addr_out !== '0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b ov=%b ill=%b busy=%b done=%b instr=%h addr=%0d, want all 0",
               in_ready, out_valid, illegal, busy, done, instr_out, addr_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b ov=%b, want 0 0 0", busy, done, out_valid);
    end
  endtask

  task automatic test_directed();
    burst = {};
    burst.push_back(mkx(mk(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd2, 32'd1), 32'h0010A103, 1'b0));
    run_burst(0, 100, 100, "load");
    burst = {};
    burst.push_back(mkx(mk(7'b1100011, 3'b001, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8), 32'h00111463, 1'b0));
    burst.push_back(mkx(mk(7'b0100011, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, -32'sd4), 32'hFE112E23, 1'b0));
    run_burst(5, 100, 100, "br_st");
    burst = {};
    burst.push_back(mkx(mk(7'b0110011, 3'b000, 1'b1, 5'd2, 5'd3, 5'd1, 32'd0), 32'h403100B3, 1'b0));
    burst.push_back(mkx(mk(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd0, 5'd1, 32'd3), 32'h4030D093, 1'b0));
    run_burst(0, 100, 100, "r_srai");
  endtask

  task automatic test_illegal();
    burst = {};
    burst.push_back(mkx(mk(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3), 32'h00000013, 1'b1));
    burst.push_back(mkx(mk(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0), 32'h00000013, 1'b1));
    burst.push_back(mk(7'b0010011, 3'b000, 1'b0, 5'd4, 5'd0, 5'd5, 32'd100));
    burst.push_back(mk(7'b0010011, 3'b001, 1'b0, 5'd4, 5'd0, 5'd5, 32'd32));
    run_burst(100, 100, 100, "illegal");
  endtask

  task automatic test_backpressure();
    fields_t f[3];
    exp_t    e[3];
    for (int i = 0; i < 3; i++) begin
      f[i] = rand_fields();
      e[i] = model(f[i]);
    end
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(200); len = LEN_W'(3);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    apply_fields(f[0]);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_ready: got in_ready=%b, want 1", in_ready);
    end
    @(negedge clk);
    apply_fields(f[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr_out !== e[0].word || addr_out !== ADDR_W'(200)) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got rdy=%b ov=%b instr=%h addr=%0d, want 0 1 %h 200",
                 c, in_ready, out_valid, instr_out, addr_out, e[0].word);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) apply_fields(f[k + 1]);
      else in_valid = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || instr_out !== e[k].word || illegal !== e[k].ill ||
          addr_out !== ADDR_W'(200 + k) || in_ready !== (k < 2)) begin
        n_fail++;
        $display("FAIL bp_stream%0d: got ov=%b instr=%h ill=%b addr=%0d rdy=%b, want 1 %h %b %0d %b",
                 k, out_valid, instr_out, illegal, addr_out, in_ready, e[k].word, e[k].ill, 200 + k, k < 2);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: got done=%b ov=%b, want 1 0", done, out_valid);
    end
  endtask

  task automatic test_wrap();
    burst = {};
    burst.push_back(rand_fields());
    burst.push_back(rand_fields());
    run_burst(1023, 100, 100, "wrap");
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(3); len = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero: got done=%b busy=%b ov=%b rdy=%b, want 1 0 0 0", done, busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(7); len = LEN_W'(5);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    apply_fields(rand_fields());
    repeat (2) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || addr_out !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got ov=%b busy=%b done=%b rdy=%b addr=%0d, want 0 0 0 0 0",
               out_valid, busy, done, in_ready, addr_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      burst = {};
      for (int i = 0; i < $urandom_range(1, 24); i++) burst.push_back(rand_fields());
      run_burst($urandom_range(0, 1023), $urandom_range(30, 100), $urandom_range(40, 100), "random");
    end
  endtask

  task automatic test_back_to_back();
    burst = {};
    for (int i = 0; i < 12; i++) burst.push_back(rand_fields());
    run_burst(500, 100, 100, "b2b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
